data_mem_io: RTL and testbench
==============================

DATA_MEM_IO -- requirements
Module: data_mem_io

Interface
REQ-001 Parameter: RAM_AW, default 8, RAM word-address width; the RAM holds 2^RAM_AW 32-bit words.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 memwrite  input  1  write strobe from the core, sampled at the rising edge of clk.
REQ-005 aluout  input  32  byte address from the core; bits [1:0] ignored (word access only).
REQ-006 writedata  input  32  store data from the core.
REQ-007 readdata  output  32  load data to the core; combinational from aluout and current state.
REQ-008 tx_data  output  8  head entry of the transmit FIFO.
REQ-009 tx_valid  output  1  high while the transmit FIFO is non-empty.
REQ-010 tx_ready  input  1  the external consumer accepts tx_data when tx_valid and tx_ready are both high at a rising edge.

Function
REQ-011 Address decode: aluout[31:16]==16'hFFFF selects MMIO; all other addresses select RAM word aluout[RAM_AW+1:2]; upper RAM address bits are ignored (aliasing).
REQ-012 RAM write: memwrite=1 in the RAM region writes writedata at the rising edge; the read is combinational, so a same-cycle read returns the old word.
REQ-013 MMIO register 0xFFFF0000, CYCLES: 32-bit counter, +1 every cycle, wraps 32'hFFFFFFFF->0.
- Read returns the current value.
- A write loads writedata; the counter does not increment in that cycle.
REQ-014 MMIO register 0xFFFF0004, TXDATA.
- A write pushes writedata[7:0] into the FIFO.
- A read returns 0.
REQ-015 MMIO register 0xFFFF0008, STATUS.
- Read returns {27'b0, ovf, full, count[2:0]}.
- A write with writedata[4]=1 clears ovf; other bits are ignored.
REQ-016 Any other MMIO address: read returns 32'h0, write ignored; RAM is not modified by any MMIO access.
REQ-017 FIFO structure: depth 4, circular buffer, 2-bit read and write pointers wrapping 3->0, count 0..4; full = (count==4).
REQ-018 FIFO output: tx_valid = (count!=0); tx_data = entry at the read pointer, registered storage with no combinational path from writedata.
REQ-019 Pop: tx_valid && tx_ready at an edge advances the read pointer and decrements count.
REQ-020 Push: a TXDATA write while not full stores the byte, advances the write pointer and increments count.
REQ-021 Push while full with no pop in the same cycle: the byte is dropped, FIFO state is unchanged, and ovf is set (sticky).
REQ-022 Push and pop in the same cycle: both take effect and count is unchanged, including when full (no overflow) and when empty (the push completes; tx_valid rises next cycle; the pop is invalid because tx_valid=0).
REQ-023 Push to a full FIFO and a STATUS write clearing ovf in the same cycle cannot coexist (single address); an overflow in any cycle takes effect at that edge.
REQ-024 Stability: tx_data and tx_valid hold stable while tx_valid=1 and tx_ready=0.
REQ-025 STATUS read visibility: a STATUS read reflects state before the current edge; no bypass.

Reset
REQ-026 Asserting reset immediately clears:
- CYCLES=0;
- FIFO pointers=0, count=0;
- ovf=0;
- tx_valid=0 and tx_data=8'h00 (storage cleared).
REQ-027 RAM contents are not affected by reset.
REQ-028 Reset asserted mid-operation discards FIFO contents and any write in that cycle.
REQ-029 The first increment of CYCLES occurs at the first rising edge after reset deasserts.

Verification
REQ-030 Write 32'hDEADBEEF to 0x00000010, then read 0x00000010 and 0x00000410 (RAM_AW=8) -> both return 32'hDEADBEEF; read 0xFFFF000C -> 0.
REQ-031 Release reset and hold idle 5 cycles, then read CYCLES -> 5; write 32'hFFFFFFFE, then after 2 edges read -> 32'h00000000 (wrap).
REQ-032 With tx_ready=0, push 8'h41, 42, 43, 44, 45.
- STATUS after 4 pushes -> 32'h0000000C.
- After the fifth push -> 32'h0000001C.
- tx_data stays 8'h41.
REQ-033 Then raise tx_ready -> bytes 41, 42, 43, 44 emitted on 4 consecutive edges; tx_valid=0 afterward; STATUS -> 32'h00000010; write STATUS with 32'h10 -> 0.
REQ-034 With the FIFO full and tx_ready=1, push 8'h55 -> count stays 4, ovf stays 0, and 8'h55 is emitted last.
REQ-035 Assert reset asynchronously (between edges) with 3 entries queued -> tx_valid falls before the next edge, STATUS=0, and RAM word written before reset still reads back.

Source files
------------

// File: rtl/data_mem_io_if.sv
// Core-side data bus plus transmit-FIFO stream for data_mem_io.
//   memwrite  : store strobe from the core
//   aluout    : byte address from the core (bits [1:0] unused)
//   writedata : store data from the core
//   readdata  : load data back to the core
//   tx_data   : head byte of the transmit FIFO
//   tx_valid  : transmit FIFO non-empty
//   tx_ready  : external consumer accepts tx_data
// master = core/consumer side, slave = data_mem_io.
interface data_mem_io_if;
  logic        memwrite;
  logic [31:0] aluout;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output memwrite, aluout, writedata, tx_ready,
    input  readdata, tx_data, tx_valid
  );

  modport slave (
    input  memwrite, aluout, writedata, tx_ready,
    output readdata, tx_data, tx_valid
  );
endinterface

// File: rtl/data_mem_io.sv
// Data memory with memory-mapped I/O for a small core.
//   RAM   : 2^RAM_AW 32-bit words, combinational read, write at rising edge,
//           not cleared by reset.
//   MMIO  : aluout[31:16]==16'hFFFF
//           0xFFFF0000 CYCLES  free-running cycle counter, writable
//           0xFFFF0004 TXDATA  write pushes a byte into the transmit FIFO
//           0xFFFF0008 STATUS  {27'b0, ovf, full, count[2:0]}, write bit4 clears ovf
//   FIFO  : 4-entry byte queue drained through tx_data/tx_valid/tx_ready.
// Ports:
//   clk   : single clock, rising edge
//   reset : asynchronous, active-high
//   bus   : data_mem_io_if.slave (core bus and transmit stream)
module data_mem_io #(
  parameter int RAM_AW = 8
) (
  input  logic            clk,
  input  logic            reset,
  data_mem_io_if.slave    bus
);

  localparam logic [13:0] REG_CYCLES = 14'd0;
  localparam logic [13:0] REG_TXDATA = 14'd1;
  localparam logic [13:0] REG_STATUS = 14'd2;

  logic [31:0] ram [2**RAM_AW];

  logic [31:0] cycles;
  logic [7:0]  fifo_mem [4];
  logic [1:0]  wptr;
  logic [1:0]  rptr;
  logic [2:0]  count;
  logic        ovf;

  logic              is_mmio;
  logic [13:0]       reg_sel;
  logic [RAM_AW-1:0] ram_addr;
  logic              ram_we;
  logic              cycles_we;
  logic              push_req;
  logic              pop;
  logic              full;
  logic              push_ok;
  logic              ovf_set;
  logic              ovf_clr;

  // Byte-lane bits are never used: accesses are whole words only.
  wire unused_addr_lsbs = ^bus.aluout[1:0];

  assign is_mmio  = (bus.aluout[31:16] == 16'hFFFF);
  assign reg_sel  = bus.aluout[15:2];
  assign ram_addr = bus.aluout[RAM_AW+1:2];

  assign full = (count == 3'd4);
  assign pop  = bus.tx_valid && bus.tx_ready;

  // A pop in the same edge frees a slot, so a push into a full FIFO
  // still lands when the head is being consumed.
  assign push_req  = bus.memwrite && is_mmio && (reg_sel == REG_TXDATA);
  assign push_ok   = push_req && (!full || pop);
  assign ovf_set   = push_req && full && !pop;
  assign ovf_clr   = bus.memwrite && is_mmio && (reg_sel == REG_STATUS) && bus.writedata[4];
  assign cycles_we = bus.memwrite && is_mmio && (reg_sel == REG_CYCLES);
  // Gated by reset so a store coinciding with reset is discarded.
  assign ram_we    = bus.memwrite && !is_mmio && !reset;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[ram_addr] <= bus.writedata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycles <= 32'd0;
    end else if (cycles_we) begin
      cycles <= bus.writedata;
    end else begin
      cycles <= cycles + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        fifo_mem[i] <= 8'h00;
      end
      wptr  <= 2'd0;
      rptr  <= 2'd0;
      count <= 3'd0;
      ovf   <= 1'b0;
    end else begin
      if (push_ok) begin
        fifo_mem[wptr] <= bus.writedata[7:0];
        wptr           <= wptr + 2'd1;
      end
      if (pop) begin
        rptr <= rptr + 2'd1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      if (ovf_set) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

  assign bus.tx_valid = (count != 3'd0);
  assign bus.tx_data  = fifo_mem[rptr];

  always_comb begin
    bus.readdata = 32'h0;
    if (is_mmio) begin
      case (reg_sel)
        REG_CYCLES: bus.readdata = cycles;
        REG_STATUS: bus.readdata = {27'b0, ovf, full, count};
        default:    bus.readdata = 32'h0;
      endcase
    end else begin
      bus.readdata = ram[ram_addr];
    end
  end

endmodule

// File: tb/tb_data_mem_io.sv
module tb_data_mem_io;

  localparam logic [31:0] A_CYCLES = 32'hFFFF0000;
  localparam logic [31:0] A_TXDATA = 32'hFFFF0004;
  localparam logic [31:0] A_STATUS = 32'hFFFF0008;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;

  data_mem_io_if bus();

  data_mem_io #(.RAM_AW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus.aluout    = addr;
    bus.writedata = data;
    bus.memwrite  = 1'b1;
    @(posedge clk);
    #1;
    bus.memwrite  = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    bus.memwrite = 1'b0;
    bus.aluout   = addr;
    #1;
    chk(tag, bus.readdata, exp);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset         = 1'b1;
    bus.memwrite  = 1'b0;
    bus.aluout    = 32'h0;
    bus.writedata = 32'h0;
    bus.tx_ready  = 1'b0;
    #2;
    chk("rst_tx_valid", {31'b0, bus.tx_valid}, 32'h0);
    chk("rst_tx_data", {24'b0, bus.tx_data}, 32'h0);
    rd("rst_status", A_STATUS, 32'h0);
    rd("rst_cycles", A_CYCLES, 32'h0);

    // cycle counter and wrap
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    rd("cycles_5", A_CYCLES, 32'd5);
    wr(A_CYCLES, 32'hFFFFFFFE);
    rd("cycles_load", A_CYCLES, 32'hFFFFFFFE);
    @(posedge clk);
    rd("cycles_max", A_CYCLES, 32'hFFFFFFFF);
    @(posedge clk);
    rd("cycles_wrap", A_CYCLES, 32'h0);

    // RAM, aliasing, unmapped MMIO
    wr(32'h00000010, 32'hDEADBEEF);
    rd("ram_rd", 32'h00000010, 32'hDEADBEEF);
    rd("ram_alias", 32'h00000410, 32'hDEADBEEF);
    rd("mmio_unmapped", 32'hFFFF000C, 32'h0);
    rd("txdata_rd", A_TXDATA, 32'h0);
    bus.aluout    = 32'h00000010;
    bus.writedata = 32'h01234567;
    bus.memwrite  = 1'b1;
    #1;
    chk("ram_old_word", bus.readdata, 32'hDEADBEEF);
    @(posedge clk);
    #1;
    bus.memwrite = 1'b0;
    rd("ram_new_word", 32'h00000010, 32'h01234567);
    wr(32'hFFFF0010, 32'h12345678);
    rd("ram_no_mmio_wr", 32'h00000010, 32'h01234567);

    // fill, overflow, hold
    for (int i = 0; i < 5; i++) begin
      wr(A_TXDATA, 32'h41 + i);
      chk("tx_hold_data", {24'b0, bus.tx_data}, 32'h41);
      chk("tx_hold_valid", {31'b0, bus.tx_valid}, 32'h1);
      if (i == 3) rd("status_full", A_STATUS, 32'h0000000C);
    end
    rd("status_ovf", A_STATUS, 32'h0000001C);

    // drain
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", {31'b0, bus.tx_valid}, 32'h1);
      chk("drain_data", {24'b0, bus.tx_data}, 32'h41 + i);
      @(posedge clk);
      #1;
    end
    chk("drained_valid", {31'b0, bus.tx_valid}, 32'h0);
    rd("status_empty_ovf", A_STATUS, 32'h00000010);
    wr(A_STATUS, 32'h10);
    rd("status_clear", A_STATUS, 32'h0);

    // push into empty FIFO with consumer ready: the pop is not valid
    wr(A_TXDATA, 32'h99);
    chk("empty_push_valid", {31'b0, bus.tx_valid}, 32'h1);
    chk("empty_push_data", {24'b0, bus.tx_data}, 32'h99);
    rd("empty_push_status", A_STATUS, 32'h1);
    @(posedge clk);
    #1;
    chk("empty_push_popped", {31'b0, bus.tx_valid}, 32'h0);

    // push into a full FIFO while it is being popped
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) wr(A_TXDATA, 32'h61 + i);
    bus.tx_ready = 1'b1;
    wr(A_TXDATA, 32'h55);
    bus.tx_ready = 1'b0;
    rd("full_pushpop_status", A_STATUS, 32'h0000000C);
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("pushpop_data", {24'b0, bus.tx_data}, (i == 3) ? 32'h55 : 32'h62 + i);
      @(posedge clk);
      #1;
    end
    chk("pushpop_drained", {31'b0, bus.tx_valid}, 32'h0);

    // asynchronous reset with entries queued
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) wr(A_TXDATA, 32'h71 + i);
    wr(32'h00000040, 32'hCAFEF00D);
    chk("pre_rst_valid", {31'b0, bus.tx_valid}, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_valid", {31'b0, bus.tx_valid}, 32'h0);
    chk("async_rst_data", {24'b0, bus.tx_data}, 32'h0);
    rd("async_rst_status", A_STATUS, 32'h0);
    rd("ram_survives_rst", 32'h00000040, 32'hCAFEF00D);
    rd("async_rst_cycles", A_CYCLES, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    rd("first_incr", A_CYCLES, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
